// File: rtl/uart_pkg.sv
// Shared UART constants and helpers.
package uart_pkg;

    localparam int unsigned UART_DATA_W        = 8;
    localparam int unsigned UART_FIFO_DEPTH    = 16;
    localparam int unsigned UART_FIFO_LOW_MARK = 4;

    // Pointer width for a power-of-two FIFO depth.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Flop-array storage for the UART TX FIFO: one write port, combinational read.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = UART_FIFO_DEPTH
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_we,
    input  logic [$clog2(DEPTH)-1:0]   i_waddr,
    input  logic [UART_DATA_W-1:0]     i_wdata,
    input  logic [$clog2(DEPTH)-1:0]   i_raddr,
    output logic [UART_DATA_W-1:0]     o_rdata
);

    logic [UART_DATA_W-1:0] mem_q [DEPTH];

    // Storage is reset so the head byte reads as zero out of reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter, with level, overflow and low-watermark status.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH    = UART_FIFO_DEPTH,
    parameter int unsigned LOW_MARK = UART_FIFO_LOW_MARK
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [UART_DATA_W-1:0]   i_wr_data,
    input  logic                     i_wr_en,
    input  logic                     i_flush,
    input  logic                     i_clr_ovf,
    output logic [UART_DATA_W-1:0]   o_tx_data,
    output logic                     o_tx_valid,
    input  logic                     i_tx_ready,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow,
    output logic                     o_irq_low
);

    localparam int unsigned PtrW = ptr_w(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullLevel = DEPTH[CntW-1:0];
    localparam logic [CntW-1:0] LowLevel  = LOW_MARK[CntW-1:0];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            push, pop, mem_we;

    always_comb begin
        push     = i_wr_en & ~o_full;
        pop      = o_tx_valid & i_tx_ready;
        mem_we   = push & ~i_flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end

        // A dropped write in the same cycle as a clear leaves the flag set.
        if (i_clr_ovf)          ovf_d = 1'b0;
        if (i_wr_en && o_full)  ovf_d = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (mem_we),
        .i_waddr (wr_ptr_q),
        .i_wdata (i_wr_data),
        .i_raddr (rd_ptr_q),
        .o_rdata (o_tx_data)
    );

    assign o_level    = count_q;
    assign o_empty    = (count_q == '0);
    assign o_full     = (count_q == FullLevel);
    assign o_tx_valid = ~o_empty;
    assign o_overflow = ovf_q;
    assign o_irq_low  = (count_q <= LowLevel);

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte FIFO between the CPU peripheral write path and the UART transmitter. Bytes written by software are buffered and presented on a valid/ready stream, which the transmitter consumes one byte per frame. The block provides level, full/empty, a sticky overflow flag and a low-watermark interrupt so firmware can refill in bursts instead of polling per byte.

## Interface
- DEPTH, 16: storage entries; power of two, 2..256.
- LOW_MARK, 4: o_irq_low asserts while o_level <= LOW_MARK; 0..DEPTH-1.
- i_clk  in  1  single clock, rising edge.
- i_rst_n  in  1  reset; asynchronous and active-low.
- i_wr_data  in  8  byte to enqueue.
- i_wr_en  in  1  enqueue strobe, one byte per cycle.
- i_flush  in  1  synchronous clear of contents.
- i_clr_ovf  in  1  clears o_overflow.
- o_tx_data  out  8  head byte to transmitter.
- o_tx_valid  out  1  head byte valid (FIFO non-empty).
- i_tx_ready  in  1  transmitter accepts byte this cycle.
- o_full  out  1  level == DEPTH.
- o_empty  out  1  level == 0.
- o_level  out  $clog2(DEPTH)+1  entries stored.
- o_overflow  out  1  sticky: a write was dropped.
- o_irq_low  out  1  level <= LOW_MARK.

## Operation
- Circular buffer: wr_ptr, rd_ptr each $clog2(DEPTH) bits, wrap naturally modulo DEPTH; separate count register of $clog2(DEPTH)+1 bits drives o_level.
- Push = i_wr_en & !o_full. i_wr_en while o_full: byte dropped, o_overflow set next cycle, contents unchanged.
- Pop = o_tx_valid & i_tx_ready. i_tx_ready while empty: no effect.
- Push and pop in same cycle: both occur, level unchanged; push into full FIFO is refused even if pop also occurs (o_full is the only write gate).
- o_tx_valid = !o_empty; o_tx_data = storage[rd_ptr]; stable while o_tx_valid high and no pop.
- i_flush: pointers and count to 0 next edge; priority over push and pop in that cycle; o_overflow not affected. A byte already popped into the transmitter is not recalled.
- i_clr_ovf clears o_overflow; if an overflowing write occurs in the same cycle, set wins.
- Reset: pointers, count 0; o_tx_valid 0, o_empty 1, o_full 0, o_level 0, o_overflow 0, o_irq_low 1 (0 <= LOW_MARK); o_tx_data 8'h00 (storage reset to zero).

## Timing
- All state updates on rising i_clk; status outputs derived from registered count, valid in the cycle after the causing edge.
- Write-to-valid latency: byte pushed at edge N into empty FIFO -> o_tx_valid=1 and o_tx_data=byte after edge N.
- Pop at edge N -> next head on o_tx_data after edge N; back-to-back pops every cycle permitted.
- Transmitter drops i_tx_ready for a full frame after each acceptance; FIFO must tolerate ready low for any number of cycles with valid held.
- Reset assertion mid-transfer: all outputs to reset values immediately (asynchronous); deassertion synchronous to i_clk is handled at system level.

## Structure
- Shared package uart_pkg: UART_DATA_W = 8, default DEPTH and LOW_MARK, function for pointer width.
- One sub-module natural: uart_fifo_mem, DEPTH x 8 flop array, single write port, asynchronous read port addressed by rd_ptr. Pointer/count/flag logic stays in uart_tx_fifo.

## Test plan
- Reset then write 8'hA5 -> o_tx_valid=1, o_tx_data=8'hA5, o_level=1 one cycle later; assert ready -> o_empty=1 next cycle.
- Write 16 bytes 8'h00..8'h0F with ready low -> o_full=1, o_level=16; 17th write 8'hFF -> o_overflow=1, drain yields 8'h00..8'h0F in order, 8'hFF never appears.
- Full FIFO, simultaneous write 8'h55 and pop -> pop happens, write refused, o_level=15, o_overflow=1.
- Level 3, simultaneous write and pop for 20 cycles with incrementing data -> o_level stays 3, output order matches input order, pointers wrap.
- Write 10 bytes, assert i_flush together with i_wr_en -> o_level=0, o_empty=1, o_tx_valid=0 next cycle; o_overflow unchanged.
- LOW_MARK=4: level 5 -> o_irq_low=0; one pop -> o_irq_low=1; assert i_rst_n low mid-stream -> outputs take reset values without clock edge.
